fpalu_add_arbiter: RTL and testbench
====================================

Name: fpalu_add_arbiter

Overview:
- Shares one combinational fpalu_add single-precision adder between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Uses round-robin arbitration, registers operands and result, and allows one operation in flight.
- Sits between the FP issue logic and the shared adder; the fpalu_add instance is internal to this block.

Parameters:
CNT_W, 16, width of per-requester completed-operation counters (saturating)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has operands
req0_ready  output  1  requester 0 request accepted this cycle
req0_a  input  32  requester 0 operand A (IEEE-754 single)
req0_b  input  32  requester 0 operand B
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 consumes result
rsp0_sum  output  32  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_sum  same as requester 0, for requester 1
busy  output  1  high whenever state is not IDLE
owner  output  1  requester id of operation in flight (0 when IDLE)
cnt0  output  CNT_W  completed operations for requester 0
cnt1  output  CNT_W  completed operations for requester 1

Behaviour:
- Registered state:
  - state in {IDLE, EXEC, RESP}
  - op_a, op_b (32 each)
  - sum_q (32)
  - owner (1)
  - last (1): last requester served
  - cnt0, cnt1
- Reset (async, immediate):
  - state=IDLE; op_a=op_b=sum_q=0; owner=0; last=1 (so requester 0 wins the first tie); cnt0=cnt1=0.
  - All outputs are 0 during and after reset: readies, rsp valids, rsp sums, busy.
- Arbitration, IDLE only (combinational):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester not equal to last.
  - Neither: no grant.
- Ready generation:
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid.
  - At most one ready is high in any cycle.
  - Both readies are 0 in EXEC and RESP.
- IDLE -> EXEC on accept edge: latch op_a/op_b from the granted requester; owner := grant.
- EXEC -> RESP, exactly one cycle later:
  - sum_q := fpalu_add(op_a, op_b).
  - The adder sees only registered operands, so its inputs are stable across the whole EXEC cycle.
- RESP:
  - rsp<owner>_valid=1; rsp<owner>_sum=sum_q.
  - The other rsp_valid is 0. Both rsp_sum outputs are 0 when not valid.
  - Hold until rsp<owner>_ready=1. On that edge: state := IDLE, last := owner, cnt<owner> increments (saturates at all-ones, no wrap).
  - rsp_ready from the non-owner is ignored.
- Latency and throughput:
  - rsp_valid rises 2 cycles after the accept edge.
  - With rsp_ready tied high, one operation completes every 3 cycles (accept, exec, resp).
  - The next accept happens in the IDLE cycle after the response handshake; there is no request/response overlap.
- Boundary conditions:
  - A requester dropping valid before ready: no accept, no state change.
  - Requests arriving during EXEC/RESP: stalled by ready=0, never lost.
  - Operands changing after accept: no effect on the in-flight operation.
  - Requester holding valid continuously while the other is idle: served back-to-back. Fairness applies only when both are valid.
  - rsp_ready held low indefinitely: block stays in RESP with sum stable. This stall is legal.
  - Reset mid-operation (EXEC or RESP): operation is dropped, no response issued, counters cleared.
- Arithmetic: entirely fpalu_add semantics. The arbiter does not inspect or modify operand bits.

Test Plan:
- Reset, then req0 a=3f800000 b=3f800000, rsp0_ready=1 -> req0_ready high one cycle; rsp0_valid 2 cycles later with rsp0_sum=40000000; cnt0=1; req1/rsp1 signals stay 0.
- Both valid continuously: req0 40400000+c0000000, req1 3f800000+3f800000, both rsp_ready=1 -> grants alternate 0,1,0,1; rsp0_sum=3f800000, rsp1_sum=40000000; after 4 ops cnt0=cnt1=2.
- Response stall: rsp1_ready=0 for 10 cycles after rsp1_valid -> rsp1_valid and rsp1_sum held stable; req0_valid high yet req0_ready=0 throughout; req0 accepted the cycle after the rsp1 handshake.
- Operand change after accept: req0 a changes from 3f800000 to 7f800000 the cycle after ready, b=3f800000 -> result 40000000.
- Async reset asserted mid-EXEC -> all outputs 0 immediately; no rsp_valid after release; next tie goes to requester 0.
- Counter saturation with CNT_W=2: 5 req1 ops -> cnt1 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/fpalu_add_arbiter.sv
// Round-robin sharing of one combinational single-precision adder between two
// valid/ready requesters, with registered operands/result and one operation in flight.

module fpalu_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic        w_aNan, w_bNan, w_aInf, w_bInf;
  logic        w_swap, w_sub, w_sign, w_sticky, w_roundUp;
  logic [31:0] w_big, w_small;
  logic [7:0]  w_bigExp, w_smallExp, w_diff, w_shift;
  logic [26:0] w_bigMan, w_smallMan, w_alignMan, w_norm;
  logic [27:0] w_raw;
  logic [4:0]  w_lz;
  logic [8:0]  w_exp;
  logic [30:0] w_packed;

  assign w_aNan = (i_a[30:23] == 8'hff) && (i_a[22:0] != 23'd0);
  assign w_bNan = (i_b[30:23] == 8'hff) && (i_b[22:0] != 23'd0);
  assign w_aInf = (i_a[30:23] == 8'hff) && (i_a[22:0] == 23'd0);
  assign w_bInf = (i_b[30:23] == 8'hff) && (i_b[22:0] == 23'd0);

  // Order by magnitude so the aligned operand is never the larger one.
  assign w_swap     = i_b[30:0] > i_a[30:0];
  assign w_big      = w_swap ? i_b : i_a;
  assign w_small    = w_swap ? i_a : i_b;
  assign w_bigExp   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
  assign w_smallExp = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
  assign w_bigMan   = {w_big[30:23] != 8'd0, w_big[22:0], 3'b000};
  assign w_smallMan = {w_small[30:23] != 8'd0, w_small[22:0], 3'b000};
  assign w_diff     = w_bigExp - w_smallExp;
  assign w_sub      = w_big[31] ^ w_small[31];
  assign w_sign     = w_big[31];

  // Bits shifted past guard/round collapse into a sticky LSB.
  always_comb begin
    w_alignMan = 27'd0;
    w_sticky   = 1'b0;
    if (w_diff >= 8'd27) begin
      w_sticky = |w_smallMan;
    end else begin
      w_alignMan = w_smallMan >> w_diff;
      w_sticky   = |(w_smallMan & ((27'd1 << w_diff) - 27'd1));
    end
    w_alignMan[0] = w_alignMan[0] | w_sticky;
  end

  assign w_raw = w_sub ? ({1'b0, w_bigMan} - {1'b0, w_alignMan})
                       : ({1'b0, w_bigMan} + {1'b0, w_alignMan});

  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_raw[i]) w_lz = 5'(26 - i);
    end
  end

  // Left shift stops at exponent 1 so tiny results land as denormals.
  assign w_shift = ({3'b000, w_lz} > (w_bigExp - 8'd1)) ? (w_bigExp - 8'd1) : {3'b000, w_lz};

  always_comb begin
    if (w_raw[27]) begin
      w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
      w_exp  = {1'b0, w_bigExp} + 9'd1;
    end else begin
      w_norm = w_raw[26:0] << w_shift;
      w_exp  = {1'b0, w_bigExp} - {1'b0, w_shift};
    end
  end

  // Round-to-nearest-even; the carry ripples into the exponent field on its own.
  assign w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_packed  = {(w_norm[26] ? w_exp[7:0] : 8'd0), w_norm[25:3]} + {30'd0, w_roundUp};

  always_comb begin
    if (w_aNan || w_bNan || (w_aInf && w_bInf && (i_a[31] != i_b[31]))) begin
      o_sum = 32'h7fc00000;
    end else if (w_aInf) begin
      o_sum = i_a;
    end else if (w_bInf) begin
      o_sum = i_b;
    end else if (w_raw == 28'd0) begin
      o_sum = {i_a[31] & i_b[31], 31'd0};
    end else if (w_norm[26] && (w_exp >= 9'd255)) begin
      o_sum = {w_sign, 8'hff, 23'd0};
    end else begin
      o_sum = {w_sign, w_packed};
    end
  end
endmodule

module fpalu_add_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_sum,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_sum,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_opA, r_opB, r_sum;
  logic             r_owner, r_last;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  logic             w_idle, w_grant, w_accept, w_done;
  logic [31:0]      w_addSum;

  assign w_idle = (r_state == S_IDLE);

  // Ties go to whoever was not served last; a lone requester always wins.
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = ~rst & w_idle & req0_valid & ~w_grant;
  assign req1_ready = ~rst & w_idle & req1_valid & w_grant;
  assign w_accept   = req0_ready | req1_ready;

  assign rsp0_valid = (r_state == S_RESP) & ~r_owner;
  assign rsp1_valid = (r_state == S_RESP) & r_owner;
  assign rsp0_sum   = rsp0_valid ? r_sum : 32'd0;
  assign rsp1_sum   = rsp1_valid ? r_sum : 32'd0;
  assign w_done     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign busy  = ~w_idle;
  assign owner = w_idle ? 1'b0 : r_owner;
  assign cnt0  = r_cnt0;
  assign cnt1  = r_cnt1;

  fpalu_add u_add (
    .i_a   (r_opA),
    .i_b   (r_opB),
    .o_sum (w_addSum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opA   <= 32'd0;
      r_opB   <= 32'd0;
      r_sum   <= 32'd0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opA   <= w_grant ? req1_a : req0_a;
            r_opB   <= w_grant ? req1_b : req0_b;
            r_owner <= w_grant;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_sum   <= w_addSum;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_last  <= r_owner;
            if (r_owner) begin
              if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
              if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpalu_add_arbiter.sv
// Directed bench for fpalu_add_arbiter: a cycle model plus a result scoreboard
// checks every output each cycle, with directed checks at the interesting points.

module tb_fpalu_add_arbiter;
  localparam int          CNT_W   = 2;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic             clk, rst;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0]      req0_a, req0_b, rsp0_sum, req1_a, req1_b, rsp1_sum;
  logic             busy, owner;
  logic [CNT_W-1:0] cnt0, cnt1;

  typedef struct {
    logic        id;
    logic [31:0] sum;
  } sbItem_t;

  sbItem_t     sb[$];
  int          mState;
  logic        mLast;
  logic [31:0] mCnt0, mCnt1;
  int          nAsserts, nFails;

  logic [31:0] satA[5]   = '{32'h3f800000, 32'h3f800000, 32'h00000001, 32'h3fc00000, 32'h3f800000};
  logic [31:0] satB[5]   = '{32'hbf800000, 32'h33800000, 32'h00000001, 32'h40100000, 32'h33800001};
  logic [31:0] satCnt[5] = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

  fpalu_add_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_sum   (rsp0_sum),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_sum   (rsp1_sum),
    .busy       (busy),
    .owner      (owner),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Known IEEE-754 single results for every operand pair the bench drives.
  function automatic logic [31:0] expectedSum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3f800000, 32'h3f800000}: return 32'h40000000;
      {32'h40400000, 32'hc0000000}: return 32'h3f800000;
      {32'h3fc00000, 32'h40100000}: return 32'h40700000;
      {32'h7f800000, 32'h3f800000}: return 32'h7f800000;
      {32'h3f800000, 32'hbf800000}: return 32'h00000000;
      {32'h3f800000, 32'h33800000}: return 32'h3f800000;
      {32'h00000001, 32'h00000001}: return 32'h00000002;
      {32'h3f800000, 32'h33800001}: return 32'h3f800001;
      default:                      return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic r0, input logic r1);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    rsp0_ready = r0;
    rsp1_ready = r1;
  endtask

  // Compare all outputs against the model at the falling edge, then advance the model
  // to match the coming rising edge and return just after it.
  task automatic step();
    logic        eR0, eR1, eV0, eV1, eOwn;
    logic [31:0] eSum;
    @(negedge clk);
    eOwn = (mState != 0 && sb.size() > 0) ? sb[0].id : 1'b0;
    eSum = (sb.size() > 0) ? sb[0].sum : 32'd0;
    eR0  = (mState == 0) && req0_valid && (!req1_valid || mLast);
    eR1  = (mState == 0) && req1_valid && (!req0_valid || !mLast);
    eV0  = (mState == 2) && !eOwn;
    eV1  = (mState == 2) && eOwn;
    checkOutput("req0_ready", req0_ready, eR0);
    checkOutput("req1_ready", req1_ready, eR1);
    checkOutput("rsp0_valid", rsp0_valid, eV0);
    checkOutput("rsp1_valid", rsp1_valid, eV1);
    checkOutput("rsp0_sum", rsp0_sum, eV0 ? eSum : 32'd0);
    checkOutput("rsp1_sum", rsp1_sum, eV1 ? eSum : 32'd0);
    checkOutput("busy", busy, mState != 0);
    checkOutput("owner", owner, eOwn);
    checkOutput("cnt0", cnt0, mCnt0);
    checkOutput("cnt1", cnt1, mCnt1);
    case (mState)
      0: if (eR0 || eR1) begin
           sb.push_back('{id: eR1, sum: eR1 ? expectedSum(req1_a, req1_b) : expectedSum(req0_a, req0_b)});
           mState = 1;
         end
      1: mState = 2;
      default: if ((eV0 && rsp0_ready) || (eV1 && rsp1_ready)) begin
           mLast = eOwn;
           if (eOwn) mCnt1 = (mCnt1 == CNT_MAX) ? mCnt1 : mCnt1 + 32'd1;
           else      mCnt0 = (mCnt0 == CNT_MAX) ? mCnt0 : mCnt0 + 32'd1;
           void'(sb.pop_front());
           mState = 0;
         end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req0_ready"}, req0_ready, 0);
    checkOutput({tag, "_req1_ready"}, req1_ready, 0);
    checkOutput({tag, "_rsp0_valid"}, rsp0_valid, 0);
    checkOutput({tag, "_rsp1_valid"}, rsp1_valid, 0);
    checkOutput({tag, "_rsp0_sum"}, rsp0_sum, 0);
    checkOutput({tag, "_rsp1_sum"}, rsp1_sum, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_owner"}, owner, 0);
    checkOutput({tag, "_cnt0"}, cnt0, 0);
    checkOutput({tag, "_cnt1"}, cnt1, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkAllZero("rst");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mState = 0;
    mLast  = 1'b1;
    mCnt0  = 32'd0;
    mCnt1  = 32'd0;
    sb.delete();
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    doReset();

    // Single request from requester 0: 1.0 + 1.0.
    applyStimulus(1, 32'h3f800000, 32'h3f800000, 0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();
    checkOutput("t1_cnt0", cnt0, 1);

    // Both requesters hold valid: grants alternate 0,1,0,1.
    doReset();
    applyStimulus(1, 32'h40400000, 32'hc0000000, 1, 32'h3f800000, 32'h3f800000, 1, 1);
    repeat (12) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    step();
    checkOutput("t2_cnt0", cnt0, 2);
    checkOutput("t2_cnt1", cnt1, 2);

    // Response stall on requester 1 while requester 0 waits.
    doReset();
    applyStimulus(0, 0, 0, 1, 32'h3f800000, 32'h3f800000, 0, 0);
    step();
    applyStimulus(1, 32'h3fc00000, 32'h40100000, 0, 0, 0, 0, 0);
    repeat (11) step();
    checkOutput("t3_stall_sum", rsp1_sum, 32'h40000000);
    applyStimulus(1, 32'h3fc00000, 32'h40100000, 0, 0, 0, 0, 1);
    step();
    checkOutput("t3_req0_ready_after", req0_ready, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step();

    // Operand A changes right after accept; second accept sees the new value.
    doReset();
    applyStimulus(1, 32'h3f800000, 32'h3f800000, 0, 0, 0, 1, 0);
    step();
    applyStimulus(1, 32'h7f800000, 32'h3f800000, 0, 0, 0, 1, 0);
    step();
    checkOutput("t4_inflight_sum", rsp0_sum, 32'h40000000);
    repeat (4) step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    step();

    // Async reset while an operation is in EXEC.
    doReset();
    applyStimulus(0, 0, 0, 1, 32'h3f800000, 32'h3f800000, 0, 1);
    step();
    checkOutput("t5_busy_exec", busy, 1);
    rst = 1'b1;
    #1;
    checkAllZero("t5_midexec");
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step();
    applyStimulus(1, 32'h40400000, 32'hc0000000, 1, 32'h3f800000, 32'h3f800000, 1, 1);
    #1;
    checkOutput("t5_tie_req0", req0_ready, 1);
    checkOutput("t5_tie_req1", req1_ready, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step();

    // Counter saturation with a 2-bit counter, varied operands per operation.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, satA[i], satB[i], 0, 1);
      repeat (3) step();
      checkOutput($sformatf("t6_cnt1_%0d", i), cnt1, satCnt[i]);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
